// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and counter sizing for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter only needs to reach width-1; keep at least one bit for tiny widths.
  function automatic int cnt_w(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mul_abs_n.sv
// rtl/mul_abs_n.sv - operand magnitude and sign extraction
module mul_abs_n
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign sign = signed_mode & a[WIDTH-1];
  assign mag  = sign ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_mul_n_bit.sv
// rtl/seq_mul_n_bit.sv - sequential shift-add multiplier with handshake and held result
module seq_mul_n_bit
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, res_reg, addend;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;

  mul_abs_n #(.WIDTH(WIDTH)) u_abs_a (
    .a           (a),
    .signed_mode (signed_mode),
    .mag         (mag_a),
    .sign        (sign_a)
  );

  mul_abs_n #(.WIDTH(WIDTH)) u_abs_b (
    .a           (b),
    .signed_mode (signed_mode),
    .mag         (mag_b),
    .sign        (sign_b)
  );

  assign addend = {{WIDTH{1'b0}}, mcand} << cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      res_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= sign_a ^ sign_b;
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        // Result register updates only here, so it stays put through DONE and IDLE.
        FIX:  res_reg <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = res_reg;

endmodule
